// File: rtl/as6d_pcs_rx_pldb_rd_ctrl_if.sv
// Signal bundle for the PCS RX payload-buffer read controller: control, FIFO read port,
// downstream valid/ready stream and status. The controller uses modport master.
interface as6d_pcs_rx_pldb_rd_ctrl_if #(
  parameter int DATA_WIDTH = 72,
  parameter int CNT_WIDTH  = 16
);
  logic                  enable;
  logic                  flush;
  logic                  flush_done;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_data_val;
  logic                  fifo_single_err;
  logic                  fifo_double_err;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_err;
  logic                  obuf_ovf_int;
  logic [CNT_WIDTH-1:0]  single_err_cnt;
  logic [CNT_WIDTH-1:0]  double_err_cnt;

  modport master (
    input  enable, flush, fifo_empty, fifo_rd_data, fifo_rd_data_val,
           fifo_single_err, fifo_double_err, out_ready,
    output flush_done, fifo_rd_en, out_data, out_valid, out_err,
           obuf_ovf_int, single_err_cnt, double_err_cnt
  );

  modport slave (
    output enable, flush, fifo_empty, fifo_rd_data, fifo_rd_data_val,
           fifo_single_err, fifo_double_err, out_ready,
    input  flush_done, fifo_rd_en, out_data, out_valid, out_err,
           obuf_ovf_int, single_err_cnt, double_err_cnt
  );
endinterface

// File: rtl/as6d_pcs_rx_pldb_rd_ctrl.sv
// Credit-based read controller for the PCS RX payload FIFO with an output buffer, flush/drain and ECC tagging.
// Optional macro PCS_RX_PLDB_RD_DROP_DBERR_EN: drop uncorrectable words instead of forwarding them with out_err.
module as6d_pcs_rx_pldb_rd_ctrl #(
  parameter int DATA_WIDTH     = 72,
  parameter int RAM_PIPE_STAGE = 2,
  parameter int OBUF_DEPTH     = 4,
  parameter int CNT_WIDTH      = 16
) (
  input logic                        clk,
  input logic                        rst,
  as6d_pcs_rx_pldb_rd_ctrl_if.master bus
);
  localparam int PTR_W  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int OCNT_W = PTR_W + 1;
  localparam int INF_W  = $clog2(RAM_PIPE_STAGE + 1);
  localparam int SUM_W  = OCNT_W + INF_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state_q, state_d;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCNT_W-1:0]    ocnt_q, ocnt_d, ocnt_after_pop;
  logic [INF_W-1:0]     inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] sgl_cnt_q, sgl_cnt_d, dbl_cnt_q, dbl_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_WIDTH:0]  mem_q [OBUF_DEPTH];

  logic rd_en, out_valid, flush_done, obuf_clear;
  logic accept, drop_word, obuf_full, pop, push, land;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.flush) state_d = DRAIN; else if (bus.enable) state_d = RUN;
      RUN:     if (bus.flush) state_d = DRAIN; else if (!bus.enable) state_d = IDLE;
      DRAIN:   if (inflight_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Head-of-buffer view; the credit check uses the occupancy after this cycle's pop.
  assign out_valid      = (ocnt_q != '0) && (state_q != DRAIN);
  assign pop            = out_valid && bus.out_ready;
  assign ocnt_after_pop = ocnt_q - OCNT_W'(pop);

  always_comb begin
    rd_en      = 1'b0;
    flush_done = 1'b0;
    obuf_clear = 1'b0;
    unique case (state_q)
      RUN: rd_en = !bus.flush && !bus.fifo_empty &&
                   ((SUM_W'(inflight_q) + SUM_W'(ocnt_after_pop)) < SUM_W'(OBUF_DEPTH));
      DRAIN: begin
        flush_done = (inflight_q == '0);
        obuf_clear = (inflight_q == '0);
      end
      default: ;
    endcase
  end

  // Returns with nothing outstanding predate the last reset and are ignored.
  always_comb begin
    accept = bus.fifo_rd_data_val && (inflight_q != '0);
`ifdef PCS_RX_PLDB_RD_DROP_DBERR_EN
    drop_word = bus.fifo_double_err;
`else
    drop_word = 1'b0;
`endif
    obuf_full = (ocnt_q == OCNT_W'(OBUF_DEPTH));
    land      = accept && (state_q != DRAIN) && !drop_word;
    push      = land && (!obuf_full || pop);
    ovf_d     = land && obuf_full && !pop;

    inflight_d = inflight_q;
    unique case ({rd_en, accept})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: ;
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ocnt_d   = ocnt_q;
    if (obuf_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ocnt_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      ocnt_d = ocnt_q + OCNT_W'(push) - OCNT_W'(pop);
    end

    sgl_cnt_d = sgl_cnt_q;
    dbl_cnt_d = dbl_cnt_q;
    if (bus.fifo_rd_data_val && bus.fifo_single_err && (sgl_cnt_q != '1)) sgl_cnt_d = sgl_cnt_q + 1'b1;
    if (bus.fifo_rd_data_val && bus.fifo_double_err && (dbl_cnt_q != '1)) dbl_cnt_d = dbl_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ocnt_q     <= '0;
      inflight_q <= '0;
      sgl_cnt_q  <= '0;
      dbl_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ocnt_q     <= ocnt_d;
      inflight_q <= inflight_d;
      sgl_cnt_q  <= sgl_cnt_d;
      dbl_cnt_q  <= dbl_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is data-only; the head is gated by out_valid so stale entries never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.fifo_double_err, bus.fifo_rd_data};
  end

  assign bus.fifo_rd_en     = rd_en;
  assign bus.flush_done     = flush_done;
  assign bus.out_valid      = out_valid;
  assign bus.out_data       = out_valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
`ifdef PCS_RX_PLDB_RD_DROP_DBERR_EN
  assign bus.out_err        = 1'b0;
`else
  assign bus.out_err        = out_valid && mem_q[rd_ptr_q][DATA_WIDTH];
`endif
  assign bus.obuf_ovf_int   = ovf_q;
  assign bus.single_err_cnt = sgl_cnt_q;
  assign bus.double_err_cnt = dbl_cnt_q;
endmodule

// File: tb/tb_as6d_pcs_rx_pldb_rd_ctrl.sv
// Bench for as6d_pcs_rx_pldb_rd_ctrl: FIFO model with fixed read latency, scoreboard of expected words.
`timescale 1ns/1ps
module tb_as6d_pcs_rx_pldb_rd_ctrl;
  localparam int DW  = 72;
  localparam int RPS = 2;
  localparam int OD  = 4;
  localparam int CW  = 16;

  typedef struct packed { logic val; logic [DW-1:0] data; logic serr; logic derr; } ret_t;
  typedef struct packed { logic [DW-1:0] data; logic serr; logic derr; } word_t;
  typedef struct packed { logic [DW-1:0] data; logic err; } exp_t;

  logic clk = 1'b0;
  logic rst;

  as6d_pcs_rx_pldb_rd_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  as6d_pcs_rx_pldb_rd_ctrl #(
    .DATA_WIDTH(DW), .RAM_PIPE_STAGE(RPS), .OBUF_DEPTH(OD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  word_t   fifo_mem[$];
  exp_t    exp_q[$];
  ret_t    pipe [RPS];
  int      cyc = 0;
  int      rd_total = 0;
  int      pop_total = 0;
  logic    ovf_seen = 1'b0;
  logic    s_rd, s_valid, s_pop, s_fd, s_err;
  logic [DW-1:0] s_data;

  // One clock cycle: present FIFO returns, sample outputs, model the read and score any pop.
  task automatic cycle();
    ret_t  cur;
    word_t w;
    exp_t  e;
    cur = pipe[0];
    for (int i = 0; i < RPS - 1; i++) pipe[i] = pipe[i+1];
    pipe[RPS-1] = '0;
    bus.fifo_rd_data_val = cur.val;
    bus.fifo_rd_data     = cur.data;
    bus.fifo_single_err  = cur.val & cur.serr;
    bus.fifo_double_err  = cur.val & cur.derr;
    bus.fifo_empty       = (fifo_mem.size() == 0);
    #1;
    s_rd    = bus.fifo_rd_en;
    s_valid = bus.out_valid;
    s_pop   = bus.out_valid & bus.out_ready;
    s_fd    = bus.flush_done;
    s_data  = bus.out_data;
    s_err   = bus.out_err;
    if (bus.obuf_ovf_int) ovf_seen = 1'b1;
    if (s_rd) begin
      rd_total++;
      checks++;
      if (fifo_mem.size() == 0) begin
        errors++;
        $display("FAIL rd_on_empty: fifo_rd_en=1 while model FIFO empty at cycle %0d", cyc);
      end else begin
        w = fifo_mem.pop_front();
        pipe[RPS-1] = '{val: 1'b1, data: w.data, serr: w.serr, derr: w.derr};
      end
    end
    if (s_pop) begin
      pop_total++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got out_data=%0h out_err=%0b, expected no word", s_data, s_err);
      end else begin
        e = exp_q.pop_front();
        if (s_data !== e.data || s_err !== e.err) begin
          errors++;
          $display("FAIL sb_word: got data=%0h err=%0b, expected data=%0h err=%0b", s_data, s_err, e.data, e.err);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic preload(input int n, input int serr_idx, input int derr_idx);
    word_t w;
    exp_t  e;
    for (int i = 0; i < n; i++) begin
      w.data = DW'(i);
      w.serr = (i == serr_idx);
      w.derr = (i == derr_idx);
      fifo_mem.push_back(w);
      e.data = DW'(i);
      e.err  = w.derr;
`ifdef PCS_RX_PLDB_RD_DROP_DBERR_EN
      if (!w.derr) exp_q.push_back(e);
`else
      exp_q.push_back(e);
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cycle();
    checks++;
    if ({bus.fifo_rd_en, bus.out_valid, bus.out_err, bus.flush_done, bus.obuf_ovf_int} !== 5'b0 ||
        bus.out_data !== '0 || bus.single_err_cnt !== '0 || bus.double_err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd_en=%b valid=%b err=%b fd=%b ovf=%b data=%0h cnts=%0d/%0d, required all 0",
               bus.fifo_rd_en, bus.out_valid, bus.out_err, bus.flush_done, bus.obuf_ovf_int,
               bus.out_data, bus.single_err_cnt, bus.double_err_cnt);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (s_rd !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rd_en=%b valid=%b, required 0/0", s_rd, s_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int  n_rd = 0;
    logic bad = 1'b0;
    preload(10, -1, -1);
    bus.out_ready = 1'b0;
    bus.enable    = 1'b1;
    for (int i = 0; i < 20 && n_rd < 4; i++) begin
      cycle();
      if (s_rd) n_rd++;
    end
    cycle();
    checks++;
    if (s_valid !== 1'b1) begin
      errors++;
      $display("FAIL midstream_prefill: out_valid=%b, required 1", s_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0 || bus.out_data !== '0 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL midstream_async_reset: valid=%b rd_en=%b data=%0h err=%b, required 0",
               bus.out_valid, bus.fifo_rd_en, bus.out_data, bus.out_err);
    end
    bus.enable = 1'b0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_valid || s_rd) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stray_returns: out_valid or rd_en seen after reset, required none");
    end
    fifo_mem.delete();
    exp_q.delete();
  endtask

  task automatic test_stream();
    int first_rd = -1, last_rd = -1, n_rd = 0;
    int first_pop = -1, last_pop = -1, n_pop = 0, first_val = -1, c;
    preload(10, -1, -1);
    bus.out_ready = 1'b1;
    bus.enable    = 1'b1;
    for (int i = 0; i < 40 && n_pop < 10; i++) begin
      c = cyc;
      cycle();
      if (s_rd) begin if (first_rd < 0) first_rd = c; last_rd = c; n_rd++; end
      if (s_valid && first_val < 0) first_val = c;
      if (s_pop) begin if (first_pop < 0) first_pop = c; last_pop = c; n_pop++; end
    end
    bus.enable = 1'b0;
    repeat (3) cycle();
    checks++;
    if (n_rd != 10 || last_rd - first_rd != 9) begin
      errors++;
      $display("FAIL stream_reads: reads=%0d span=%0d, required 10/9", n_rd, last_rd - first_rd);
    end
    checks++;
    if (first_val - first_rd != 3) begin
      errors++;
      $display("FAIL stream_latency: %0d cycles, required 3", first_val - first_rd);
    end
    checks++;
    if (n_pop != 10 || last_pop - first_pop != 9 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_pops: pops=%0d span=%0d left=%0d, required 10/9/0",
               n_pop, last_pop - first_pop, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n_rd = 0, n_pop = 0;
    preload(10, -1, -1);
    bus.out_ready = 1'b0;
    bus.enable    = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_rd) n_rd++;
      if (i >= 8) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== '0) begin
          errors++;
          $display("FAIL bp_hold: valid=%b data=%0h, required 1/0", s_valid, s_data);
        end
      end
    end
    checks++;
    if (n_rd != 4) begin
      errors++;
      $display("FAIL bp_credit: reads=%0d, required 4", n_rd);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      cycle();
      if (s_rd) n_rd++;
      if (s_pop) n_pop++;
    end
    bus.enable = 1'b0;
    repeat (3) cycle();
    checks++;
    if (n_pop != 10 || n_rd != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_release: pops=%0d reads=%0d left=%0d, required 10/10/0", n_pop, n_rd, exp_q.size());
    end
  endtask

  task automatic test_ecc();
    int n_pop = 0, n_err = 0, exp_pop, exp_err;
    logic [CW-1:0] s0, d0;
`ifdef PCS_RX_PLDB_RD_DROP_DBERR_EN
    exp_pop = 9; exp_err = 0;
`else
    exp_pop = 10; exp_err = 1;
`endif
    s0 = bus.single_err_cnt;
    d0 = bus.double_err_cnt;
    preload(10, 2, 5);
    bus.out_ready = 1'b1;
    bus.enable    = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      cycle();
      if (s_pop) begin n_pop++; if (s_err) n_err++; end
    end
    bus.enable = 1'b0;
    repeat (3) cycle();
    checks++;
    if (bus.single_err_cnt !== s0 + 1'b1 || bus.double_err_cnt !== d0 + 1'b1) begin
      errors++;
      $display("FAIL ecc_counts: single=%0d double=%0d, required %0d/%0d",
               bus.single_err_cnt, bus.double_err_cnt, s0 + 1, d0 + 1);
    end
    checks++;
    if (n_pop != exp_pop || n_err != exp_err) begin
      errors++;
      $display("FAIL ecc_words: pops=%0d errs=%0d, required %0d/%0d", n_pop, n_err, exp_pop, exp_err);
    end
  endtask

  task automatic test_flush();
    int rd0, p0, n_drop;
    preload(20, -1, -1);
    rd0 = rd_total;
    p0  = pop_total;
    bus.out_ready = 1'b1;
    bus.enable    = 1'b1;
    for (int i = 0; i < 30 && rd_total - rd0 < 6; i++) cycle();
    bus.enable = 1'b0;
    bus.flush  = 1'b1;
    cycle();
    bus.flush  = 1'b0;
    checks++;
    if (s_rd !== 1'b0) begin
      errors++;
      $display("FAIL flush_stop_rd: rd_en=%b in flush cycle, required 0", s_rd);
    end
    cycle();
    checks++;
    if (s_valid !== 1'b0 || s_rd !== 1'b0 || s_fd !== 1'b0) begin
      errors++;
      $display("FAIL flush_drain: valid=%b rd_en=%b fd=%b, required 0/0/0", s_valid, s_rd, s_fd);
    end
    cycle();
    checks++;
    if (s_fd !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_pulse: fd=%b two cycles after flush, required 1", s_fd);
    end
    cycle();
    checks++;
    if (s_fd !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: fd=%b valid=%b, required 0/0", s_fd, s_valid);
    end
    n_drop = (rd_total - rd0) - (pop_total - p0);
    checks++;
    if (n_drop != 2) begin
      errors++;
      $display("FAIL flush_discard: discarded=%0d, required 2", n_drop);
    end
    for (int i = 0; i < n_drop && exp_q.size() != 0; i++) void'(exp_q.pop_front());
    bus.enable = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle();
    bus.enable = 1'b0;
    repeat (3) cycle();
    checks++;
    if (exp_q.size() != 0 || pop_total - p0 != 18) begin
      errors++;
      $display("FAIL flush_resume: left=%0d pops=%0d, required 0/18", exp_q.size(), pop_total - p0);
    end
  endtask

  task automatic test_flush_idle();
    bus.enable = 1'b0;
    bus.flush  = 1'b1;
    cycle();
    bus.flush  = 1'b0;
    checks++;
    if (s_fd !== 1'b0) begin
      errors++;
      $display("FAIL idle_flush_early: fd=%b in flush cycle, required 0", s_fd);
    end
    cycle();
    checks++;
    if (s_fd !== 1'b1) begin
      errors++;
      $display("FAIL idle_flush_done: fd=%b next cycle, required 1", s_fd);
    end
    cycle();
    checks++;
    if (s_fd !== 1'b0) begin
      errors++;
      $display("FAIL idle_flush_single: fd=%b, required 0", s_fd);
    end
  endtask

  task automatic test_counter_sat();
    logic [CW-1:0] d0;
    d0 = bus.double_err_cnt;
    bus.enable           = 1'b0;
    bus.fifo_rd_data     = '0;
    bus.fifo_rd_data_val = 1'b1;
    bus.fifo_single_err  = 1'b1;
    bus.fifo_double_err  = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    bus.fifo_rd_data_val = 1'b0;
    bus.fifo_single_err  = 1'b0;
    #1;
    checks++;
    if (bus.single_err_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_single: single_err_cnt=%0h, required ffff", bus.single_err_cnt);
    end
    checks++;
    if (bus.double_err_cnt !== d0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_side: double=%0d valid=%b, required %0d/0", bus.double_err_cnt, bus.out_valid, d0);
    end
  endtask

  initial begin
    rst                  = 1'b1;
    bus.enable           = 1'b0;
    bus.flush            = 1'b0;
    bus.out_ready        = 1'b0;
    bus.fifo_empty       = 1'b1;
    bus.fifo_rd_data     = '0;
    bus.fifo_rd_data_val = 1'b0;
    bus.fifo_single_err  = 1'b0;
    bus.fifo_double_err  = 1'b0;
    for (int i = 0; i < RPS; i++) pipe[i] = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_reset_midstream();
    test_stream();
    test_backpressure();
    test_ecc();
    test_flush();
    test_flush_idle();
    checks++;
    if (ovf_seen !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pulse: obuf_ovf_int=1 seen, required never");
    end
    test_counter_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end
endmodule
